// File: rtl/ifu_fetch_if.sv
`default_nettype none
// ============================================================================
// ifu_fetch_if : PC-in / imem / decode-out bundle for the fetch unit. Rev 1.0
// ============================================================================
interface ifu_fetch_if;
    logic        ifu_rx_valid;
    logic        ifu_rx_ready;
    logic [31:0] ifu_rx_pc;
    logic        ifu_flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        ifu_tx_valid;
    logic        ifu_tx_ready;
    logic [31:0] ifu_tx_pc;
    logic [31:0] ifu_tx_inst;
    logic        ifu_tx_misalign;

    modport master (
        input  ifu_rx_valid, ifu_rx_pc, ifu_flush, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, ifu_tx_ready,
        output ifu_rx_ready, imem_req_valid, imem_req_addr,
               ifu_tx_valid, ifu_tx_pc, ifu_tx_inst, ifu_tx_misalign
    );

    modport slave (
        output ifu_rx_valid, ifu_rx_pc, ifu_flush, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, ifu_tx_ready,
        input  ifu_rx_ready, imem_req_valid, imem_req_addr,
               ifu_tx_valid, ifu_tx_pc, ifu_tx_inst, ifu_tx_misalign
    );
endinterface
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// ifu_fetch : in-order instruction fetch queue with flush/drain. Rev 1.0
// ============================================================================
module ifu_fetch #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rstn,
    ifu_fetch_if.master  bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]    pc_q   [DEPTH];
    logic [31:0]    pc_d   [DEPTH];
    logic [31:0]    inst_q [DEPTH];
    logic [31:0]    inst_d [DEPTH];
    logic [DEPTH-1:0] mis_q, mis_d, done_q, done_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  occ_q, occ_d, drop_q, drop_d;

    logic           aligned, credit_ok, rx_fire, tx_fire;
    logic [CW:0]    used;
    logic           fill_hit;
    logic [AW-1:0]  fill_idx, scan_idx;
    logic [CW-1:0]  pend_cnt;

    assign aligned   = (bus.ifu_rx_pc[1:0] == 2'b00);
    assign used      = {1'b0, occ_q} + {1'b0, drop_q};
    assign credit_ok = (used < (CW+1)'(DEPTH));

    // Outputs are gated by rstn so they read idle while reset is held.
    assign bus.imem_req_valid = rstn && bus.ifu_rx_valid && aligned && credit_ok && !bus.ifu_flush;
    assign bus.ifu_rx_ready   = rstn && credit_ok && !bus.ifu_flush && (!aligned || bus.imem_req_ready);
    assign bus.imem_req_addr  = bus.ifu_rx_pc;
    assign bus.ifu_tx_valid   = rstn && (occ_q != '0) && done_q[rd_ptr_q] && !bus.ifu_flush;
    assign bus.ifu_tx_pc       = pc_q[rd_ptr_q];
    assign bus.ifu_tx_inst     = inst_q[rd_ptr_q];
    assign bus.ifu_tx_misalign = mis_q[rd_ptr_q];

    assign rx_fire = bus.ifu_rx_valid && bus.ifu_rx_ready;
    assign tx_fire = bus.ifu_tx_valid && bus.ifu_tx_ready;

    // Oldest not-done entry is the response target; misaligned entries are born done.
    always_comb begin
        fill_hit = 1'b0;
        fill_idx = '0;
        scan_idx = '0;
        pend_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr_q + AW'(i);
            if ((CW'(i) < occ_q) && !done_q[scan_idx]) begin
                pend_cnt = pend_cnt + CW'(1);
                if (!fill_hit) begin
                    fill_hit = 1'b1;
                    fill_idx = scan_idx;
                end
            end
        end
    end

    always_comb begin
        pc_d     = pc_q;
        inst_d   = inst_q;
        mis_d    = mis_q;
        done_d   = done_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        drop_d   = drop_q;

        if (bus.ifu_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            if (drop_q == '0) begin
                drop_d = (bus.imem_rsp_valid && pend_cnt != '0) ? pend_cnt - CW'(1) : pend_cnt;
            end else begin
                drop_d = drop_q - CW'(bus.imem_rsp_valid) + pend_cnt;
            end
        end else begin
            if (bus.imem_rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else if (fill_hit) begin
                    inst_d[fill_idx] = bus.imem_rsp_data;
                    done_d[fill_idx] = 1'b1;
                end
            end
            if (rx_fire) begin
                pc_d[wr_ptr_q]   = bus.ifu_rx_pc;
                inst_d[wr_ptr_q] = aligned ? 32'h0 : NOP_INST;
                mis_d[wr_ptr_q]  = !aligned;
                done_d[wr_ptr_q] = !aligned;
                wr_ptr_d         = wr_ptr_q + AW'(1);
            end
            if (tx_fire) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            occ_d = occ_q + CW'(rx_fire) - CW'(tx_fire);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
            mis_q    <= '0;
            done_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            drop_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            mis_q    <= mis_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            drop_q   <= drop_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// tb_ifu_fetch : directed checks of ifu_fetch with an in-order memory model. Rev 1.0
// ============================================================================
module tb_ifu_fetch;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ifu_fetch_if bus();

    ifu_fetch #(.DEPTH(2), .NOP_INST(32'h0000_0013)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] memq[$];
    bit          mem_hold = 1'b0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 32'h0050_0093;
            32'h8000_0004: return 32'h0010_8113;
            default:       return {a[15:0], 16'hC0DE};
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit fl, input bit tr);
        bus.ifu_rx_valid = v;
        bus.ifu_rx_pc    = pc;
        bus.ifu_flush    = fl;
        bus.ifu_tx_ready = tr;
        #1;
    endtask

    // One clock: record the request handshake, cross the edge, then present
    // the next memory response (latency 1) at the following falling edge.
    task automatic tick();
        #1;
        if (rstn && bus.imem_req_valid && bus.imem_req_ready)
            memq.push_back(bus.imem_req_addr);
        @(posedge clk);
        @(negedge clk);
        if (!mem_hold && memq.size() > 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_data(memq.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.ifu_rx_valid   = 1'b0;
        bus.ifu_rx_pc      = '0;
        bus.ifu_flush      = 1'b0;
        bus.ifu_tx_ready   = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        @(negedge clk);

        // Reset state
        drive(1, 32'h8000_0000, 0, 1);
        check_eq("rst_rx_ready",  bus.ifu_rx_ready,    0);
        check_eq("rst_req_valid", bus.imem_req_valid,  0);
        check_eq("rst_req_addr",  bus.imem_req_addr,   32'h8000_0000);
        check_eq("rst_tx_valid",  bus.ifu_tx_valid,    0);
        check_eq("rst_tx_pc",     bus.ifu_tx_pc,       0);
        check_eq("rst_tx_inst",   bus.ifu_tx_inst,     0);
        check_eq("rst_tx_mis",    bus.ifu_tx_misalign, 0);
        rstn = 1'b1;
        drive(0, 0, 0, 1);
        tick();

        // Two aligned fetches, memory latency 1
        drive(1, 32'h8000_0000, 0, 1);
        check_eq("t1_rx_ready0",  bus.ifu_rx_ready,   1);
        check_eq("t1_req_valid0", bus.imem_req_valid, 1);
        check_eq("t1_req_addr0",  bus.imem_req_addr,  32'h8000_0000);
        tick();
        drive(1, 32'h8000_0004, 0, 1);
        check_eq("t1_rx_ready1",  bus.ifu_rx_ready,   1);
        check_eq("t1_tx_idle",    bus.ifu_tx_valid,   0);
        tick();
        drive(0, 0, 0, 1);
        check_eq("t1_tx_valid0",  bus.ifu_tx_valid,   1);
        check_eq("t1_tx_pc0",     bus.ifu_tx_pc,      32'h8000_0000);
        check_eq("t1_tx_inst0",   bus.ifu_tx_inst,    32'h0050_0093);
        check_eq("t1_tx_mis0",    bus.ifu_tx_misalign, 0);
        tick();
        check_eq("t1_tx_valid1",  bus.ifu_tx_valid,   1);
        check_eq("t1_tx_pc1",     bus.ifu_tx_pc,      32'h8000_0004);
        check_eq("t1_tx_inst1",   bus.ifu_tx_inst,    32'h0010_8113);
        tick();
        check_eq("t1_tx_empty",   bus.ifu_tx_valid,   0);

        // Back-pressure: third PC blocked until a dequeue frees credit
        drive(1, 32'h8000_0010, 0, 0);
        check_eq("t2_rx_ready_a", bus.ifu_rx_ready, 1);
        tick();
        drive(1, 32'h8000_0014, 0, 0);
        check_eq("t2_rx_ready_b", bus.ifu_rx_ready, 1);
        tick();
        drive(1, 32'h8000_0018, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_full_rx_ready",  bus.ifu_rx_ready,   0);
            check_eq("t2_full_req_valid", bus.imem_req_valid, 0);
            check_eq("t2_full_tx_pc",     bus.ifu_tx_pc,      32'h8000_0010);
            tick();
        end
        drive(1, 32'h8000_0018, 0, 1);
        check_eq("t2_deq_rx_ready", bus.ifu_rx_ready, 0);
        check_eq("t2_deq_tx_valid", bus.ifu_tx_valid, 1);
        check_eq("t2_deq_tx_inst",  bus.ifu_tx_inst,  mem_data(32'h8000_0010));
        tick();
        check_eq("t2_c_rx_ready",  bus.ifu_rx_ready,   1);
        check_eq("t2_c_req_valid", bus.imem_req_valid, 1);
        check_eq("t2_b_tx_pc",     bus.ifu_tx_pc,      32'h8000_0014);
        tick();
        drive(0, 0, 0, 1);
        check_eq("t2_c_pending", bus.ifu_tx_valid, 0);
        tick();
        check_eq("t2_c_tx_valid", bus.ifu_tx_valid, 1);
        check_eq("t2_c_tx_pc",    bus.ifu_tx_pc,    32'h8000_0018);
        check_eq("t2_c_tx_inst",  bus.ifu_tx_inst,  mem_data(32'h8000_0018));
        tick();

        // Misaligned PC: no memory request, NOP delivered next cycle
        drive(1, 32'h8000_0002, 0, 1);
        check_eq("t3_rx_ready",  bus.ifu_rx_ready,   1);
        check_eq("t3_req_valid", bus.imem_req_valid, 0);
        tick();
        drive(0, 0, 0, 1);
        check_eq("t3_tx_valid", bus.ifu_tx_valid,    1);
        check_eq("t3_tx_pc",    bus.ifu_tx_pc,       32'h8000_0002);
        check_eq("t3_tx_inst",  bus.ifu_tx_inst,     32'h0000_0013);
        check_eq("t3_tx_mis",   bus.ifu_tx_misalign, 1);
        tick();
        check_eq("t3_tx_empty", bus.ifu_tx_valid, 0);

        // Flush with two requests in flight: both responses dropped
        mem_hold = 1'b1;
        drive(1, 32'h8000_0020, 0, 1);
        tick();
        drive(1, 32'h8000_0024, 0, 1);
        check_eq("t4_rx_ready_b", bus.ifu_rx_ready, 1);
        tick();
        drive(0, 0, 1, 1);
        check_eq("t4_flush_rx_ready", bus.ifu_rx_ready, 0);
        check_eq("t4_flush_tx_valid", bus.ifu_tx_valid, 0);
        mem_hold = 1'b0;
        tick();
        drive(1, 32'h8000_0100, 0, 1);
        check_eq("t4_drain2_rx_ready", bus.ifu_rx_ready, 0);
        check_eq("t4_drain2_tx_valid", bus.ifu_tx_valid, 0);
        tick();
        check_eq("t4_drain1_rx_ready", bus.ifu_rx_ready, 1);
        check_eq("t4_drain1_tx_valid", bus.ifu_tx_valid, 0);
        tick();
        drive(0, 0, 0, 1);
        check_eq("t4_wait_tx_valid", bus.ifu_tx_valid, 0);
        tick();
        check_eq("t4_tx_valid", bus.ifu_tx_valid, 1);
        check_eq("t4_tx_pc",    bus.ifu_tx_pc,    32'h8000_0100);
        check_eq("t4_tx_inst",  bus.ifu_tx_inst,  mem_data(32'h8000_0100));
        tick();

        // Flush coincident with the only outstanding response
        drive(1, 32'h8000_0030, 0, 1);
        tick();
        drive(0, 0, 1, 1);
        check_eq("t5_flush_tx_valid", bus.ifu_tx_valid, 0);
        tick();
        drive(1, 32'h8000_0034, 0, 1);
        check_eq("t5_rx_ready",  bus.ifu_rx_ready, 1);
        check_eq("t5_tx_killed", bus.ifu_tx_valid, 0);
        tick();
        drive(0, 0, 0, 1);
        check_eq("t5_wait_tx_valid", bus.ifu_tx_valid, 0);
        tick();
        check_eq("t5_tx_valid", bus.ifu_tx_valid, 1);
        check_eq("t5_tx_pc",    bus.ifu_tx_pc,    32'h8000_0034);
        check_eq("t5_tx_inst",  bus.ifu_tx_inst,  mem_data(32'h8000_0034));
        tick();

        // Asynchronous reset with a full queue
        drive(1, 32'h8000_0040, 0, 0);
        tick();
        drive(1, 32'h8000_0044, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        check_eq("t6_pre_tx_valid", bus.ifu_tx_valid, 1);
        check_eq("t6_pre_tx_pc",    bus.ifu_tx_pc,    32'h8000_0040);
        rstn = 1'b0;
        drive(1, 32'h8000_0048, 0, 0);
        check_eq("t6_rst_tx_valid",  bus.ifu_tx_valid,    0);
        check_eq("t6_rst_rx_ready",  bus.ifu_rx_ready,    0);
        check_eq("t6_rst_req_valid", bus.imem_req_valid,  0);
        check_eq("t6_rst_tx_pc",     bus.ifu_tx_pc,       0);
        check_eq("t6_rst_tx_inst",   bus.ifu_tx_inst,     0);
        check_eq("t6_rst_tx_mis",    bus.ifu_tx_misalign, 0);
        memq.delete();
        bus.imem_rsp_valid = 1'b0;
        tick();
        rstn = 1'b1;
        drive(1, 32'h8000_0048, 0, 1);
        check_eq("t6_post_rx_ready", bus.ifu_rx_ready, 1);
        tick();
        drive(0, 0, 0, 1);
        check_eq("t6_post_wait", bus.ifu_tx_valid, 0);
        tick();
        check_eq("t6_post_tx_valid", bus.ifu_tx_valid, 1);
        check_eq("t6_post_tx_pc",    bus.ifu_tx_pc,    32'h8000_0048);
        check_eq("t6_post_tx_inst",  bus.ifu_tx_inst,  mem_data(32'h8000_0048));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
